// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM state encoding and
// the master-index width used on activeMaster.
package bus_arb_pkg;

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus interface between the arbiter and its masters. The slave modport
// is the arbiter's view; the master modport is the requesters'/bus view.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4
);
    import bus_arb_pkg::*;

    // request is a level held until grant; grant is one-hot and registered; a
    // granted master owns the bus from beginTransactionIn until endTransactionIn.
    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] grant;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   dataValidIn;
    logic                   busErrorIn;
    logic [IDX_W-1:0]       activeMaster;
    logic                   busIdle;
    logic                   endTransactionOut;
    logic                   busErrorOut;

    modport slave (
        input  request, beginTransactionIn, endTransactionIn, dataValidIn, busErrorIn,
        output grant, activeMaster, busIdle, endTransactionOut, busErrorOut
    );

    modport master (
        output request, beginTransactionIn, endTransactionIn, dataValidIn, busErrorIn,
        input  grant, activeMaster, busIdle, endTransactionOut, busErrorOut
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so the search starts one
// past ptr_i, find the first set bit, then un-rotate to a one-hot winner.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [SW-1:0]    sum;

    always_comb begin
        start   = (ptr_i >= IDX_W'(N - 1)) ? '0 : ptr_i + 1'b1;
        rot     = N'({req_i, req_i} >> start);
        off     = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && rot[i]) begin
                valid_o = 1'b1;
                off     = IDX_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        idx_o   = valid_o ? sum[IDX_W-1:0] : ptr_i;
        grant_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter tracking transaction ownership from the bus
// begin/end strobes. Define BUS_ARB_WATCHDOG_EN to add the stalled-transaction abort.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int BEGIN_TIMEOUT   = 16,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             nReset,
    bus_arbiter_rr_if.slave  bus,
    output arb_state_t       state_o
);

    localparam logic [IDX_W-1:0] RST_ACTIVE = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       active_q, active_d;
    logic                   idle_q, idle_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [8:0]             cnt_inc;
    logic                   owner_req;
    logic                   rel;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i   (bus.request),
        .ptr_i   (active_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign owner_req = |(bus.request & grant_q);

`ifdef BUS_ARB_WATCHDOG_EN
    logic [15:0] wd_q, wd_d;
    logic [16:0] wd_inc;
    logic        eo_q, eo_d, er_q, er_d;
    assign wd_inc = {1'b0, wd_q} + 17'd1;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        active_d = active_q;
        idle_d   = idle_q;
        cnt_d    = cnt_q;
        rel      = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
        wd_d = wd_q;
        eo_d = 1'b0;
        er_d = 1'b0;
`endif
        case (state_q)
            // RELEASE arbitrates too, so its single dead cycle still allows a
            // new grant two cycles after the end strobe.
            IDLE, RELEASE: begin
                grant_d = '0;
                idle_d  = 1'b1;
                state_d = IDLE;
                if (pick_valid) begin
                    grant_d  = pick_onehot;
                    active_d = pick_idx;
                    idle_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = GRANTED;
                end
            end
            GRANTED: begin
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_inc[7:0];
                end
                if (bus.beginTransactionIn && bus.endTransactionIn) begin
                    rel = 1'b1;
                end else if (bus.beginTransactionIn) begin
                    state_d = BUSY;
`ifdef BUS_ARB_WATCHDOG_EN
                    wd_d = '0;
`endif
                end else if (!owner_req || cnt_inc >= 9'(BEGIN_TIMEOUT)) begin
                    rel = 1'b1;
                end
            end
            BUSY: begin
                if (bus.endTransactionIn) begin
                    rel = 1'b1;
                end
`ifdef BUS_ARB_WATCHDOG_EN
                else if (bus.dataValidIn || bus.beginTransactionIn) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_inc[15:0];
                    if (wd_inc >= 17'(WATCHDOG_CYCLES)) begin
                        rel  = 1'b1;
                        eo_d = 1'b1;
                        er_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            grant_d = '0;
            idle_d  = 1'b1;
            state_d = RELEASE;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            active_q <= RST_ACTIVE;
            idle_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            idle_q   <= idle_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BUS_ARB_WATCHDOG_EN
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wd_q <= '0;
            eo_q <= 1'b0;
            er_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            eo_q <= eo_d;
            er_q <= er_d;
        end
    end
    assign bus.endTransactionOut = eo_q;
    assign bus.busErrorOut       = er_q;
`else
    assign bus.endTransactionOut = 1'b0;
    assign bus.busErrorOut       = 1'b0;
`endif

    // busErrorIn never changes ownership: the slave still ends the transaction.
    wire unused_ok = ^{bus.dataValidIn, bus.busErrorIn, 16'(WATCHDOG_CYCLES)};

    assign bus.grant        = grant_q;
    assign bus.activeMaster = active_q;
    assign bus.busIdle      = idle_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, every cycle
// compared against an ownership-level reference model of the arbiter.
module tb_bus_arbiter_rr;
    import bus_arb_pkg::*;

    localparam int N  = 4;
    localparam int BT = 16;
`ifdef BUS_ARB_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 1024;
`endif
    localparam int W = N + 6;

    logic       clock;
    logic       nReset;
    arb_state_t dut_state;

    bus_arbiter_rr_if #(.NUM_MASTERS(N)) bus ();

    bus_arbiter_rr #(
        .NUM_MASTERS     (N),
        .BEGIN_TIMEOUT   (BT),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clock   (clock),
        .nReset  (nReset),
        .bus     (bus),
        .state_o (dut_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: who owns the bus, whether the transaction started,
    // how long since grant, and whether a turnaround cycle is pending
    int m_owner, m_last, m_age, m_wd;
    bit m_started, m_turn, m_abort;

    task automatic model_release();
        m_owner   = -1;
        m_started = 1'b0;
        m_turn    = 1'b1;
    endtask

    task automatic model_pick(input logic [N-1:0] req);
        bit found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (!found && req[c]) begin
                found   = 1'b1;
                m_owner = c;
                m_last  = c;
                m_age   = 0;
            end
        end
    endtask

    function automatic logic [W-1:0] pack_exp();
        logic [N-1:0] g;
        g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        return {g, 3'(m_last), (m_owner < 0), m_abort, m_abort};
    endfunction

    always @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            m_owner = -1; m_last = N - 1; m_age = 0; m_wd = 0;
            m_started = 1'b0; m_turn = 1'b0; m_abort = 1'b0;
            exp_q.delete();
        end else begin
            m_abort = 1'b0;
            if (m_turn) begin
                m_turn = 1'b0;
                model_pick(bus.request);
            end else if (m_owner < 0) begin
                model_pick(bus.request);
            end else if (!m_started) begin
                m_age++;
                if (bus.beginTransactionIn && bus.endTransactionIn) model_release();
                else if (bus.beginTransactionIn) begin
                    m_started = 1'b1;
                    m_wd      = 0;
                end else if (!bus.request[m_owner] || m_age >= BT) model_release();
            end else begin
                if (bus.endTransactionIn) model_release();
`ifdef BUS_ARB_WATCHDOG_EN
                else if (bus.dataValidIn || bus.beginTransactionIn) m_wd = 0;
                else begin
                    m_wd++;
                    if (m_wd >= WD) begin
                        model_release();
                        m_abort = 1'b1;
                    end
                end
`endif
            end
        end
        exp_q.push_back(pack_exp());
    end

    // scoreboard
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("grant", 32'(bus.grant), 32'(mon_e[W-1:6]));
            check_val("active", 32'(bus.activeMaster), 32'(mon_e[5:3]));
            check_val("idle", 32'(bus.busIdle), 32'(mon_e[2]));
            check_val("end_out", 32'(bus.endTransactionOut), 32'(mon_e[1]));
            check_val("err_out", 32'(bus.busErrorOut), 32'(mon_e[0]));
            check_val("onehot", 32'($onehot0(bus.grant)), 32'd1);
            check_val("release_no_grant", 32'(dut_state == RELEASE && bus.grant != '0), 32'd0);
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (bus.grant == '0 && n < budget) begin
            step();
            n++;
        end
        check_val("grant_wait", 32'(bus.grant != '0), 32'd1);
    endtask

    task automatic begin_then_end();
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        step();
        bus.endTransactionIn   = 1'b0;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        step();
        step();
        nReset = 1'b1;
    endtask

    logic [N-1:0] seq [5];
    logic [N-1:0] exp_seq [5];
    int cnt;
    int pulses;

    initial begin
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        nReset = 1'b0;
        bus.request = '0;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.dataValidIn        = 1'b0;
        bus.busErrorIn         = 1'b0;
        step();
        step();
        check_val("rst_grant", 32'(bus.grant), 32'd0);
        check_val("rst_active", 32'(bus.activeMaster), 32'(N - 1));
        check_val("rst_idle", 32'(bus.busIdle), 32'd1);
        check_val("rst_eout", 32'(bus.endTransactionOut), 32'd0);
        nReset = 1'b1;

        // single master, begin then end five cycles later
        bus.request = 4'b0001;
        step();
        check_val("b_grant", 32'(bus.grant), 32'h1);
        check_val("b_active", 32'(bus.activeMaster), 32'd0);
        check_val("b_idle", 32'(bus.busIdle), 32'd0);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        repeat (4) step();
        bus.endTransactionIn = 1'b1;
        step();
        bus.endTransactionIn = 1'b0;
        check_val("b_end_drop", 32'(bus.grant), 32'd0);
        check_val("b_end_idle", 32'(bus.busIdle), 32'd1);
        step();
        check_val("b_regrant_t2", 32'(bus.grant), 32'h1);
        bus.beginTransactionIn = 1'b1;
        bus.endTransactionIn   = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        check_val("b_begin_end_same", 32'(bus.grant), 32'd0);
        bus.request = '0;
        step();

        // all masters requesting: strict rotation
        do_reset();
        bus.request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(8);
            seq[k] = bus.grant;
            if (k == 4) begin
                bus.beginTransactionIn = 1'b1;
                step();
                bus.beginTransactionIn = 1'b0;
                bus.endTransactionIn   = 1'b1;
                bus.request            = '0;
                step();
                bus.endTransactionIn   = 1'b0;
            end else begin
                begin_then_end();
            end
        end
        for (int k = 0; k < 5; k++) check_val($sformatf("rr_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        step();

        // begin timeout on master 2, master 3 follows
        bus.request = 4'b1100;
        wait_grant(8);
        check_val("to_grant2", 32'(bus.grant), 32'h4);
        cnt = 0;
        while (bus.grant == 4'b0100 && cnt < 40) begin
            cnt++;
            step();
        end
        check_val("to_cycles", 32'(cnt), 32'(BT));
        wait_grant(4);
        check_val("to_grant3", 32'(bus.grant), 32'h8);
        bus.request = 4'b1000;
        begin_then_end();
        bus.request = '0;
        step();

        // busy: request drop and bus error do not release
        bus.request = 4'b0001;
        wait_grant(8);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        bus.request    = '0;
        bus.busErrorIn = 1'b1;
        step();
        bus.busErrorIn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val("busy_hold", 32'(bus.grant), 32'h1);
            step();
        end
        bus.endTransactionIn = 1'b1;
        step();
        bus.endTransactionIn = 1'b0;
        check_val("busy_end_drop", 32'(bus.grant), 32'd0);
        step();

        // stalled transaction with no data
        bus.request = 4'b0010;
        wait_grant(8);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        pulses = 0;
        for (int k = 0; k < WD + 4 && k < 20; k++) begin
            step();
            if (bus.endTransactionOut) pulses++;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        check_val("wd_pulses", 32'(pulses), 32'd1);
        check_val("wd_grant_drop", 32'(bus.grant != 4'b0010 || dut_state != BUSY), 32'd1);
`else
        check_val("wd_pulses", 32'(pulses), 32'd0);
        check_val("wd_grant_held", 32'(bus.grant), 32'h2);
`endif
        bus.request = '0;
        bus.endTransactionIn = 1'b1;
        step();
        bus.endTransactionIn = 1'b0;
        step();
        step();

        // asynchronous reset in the middle of a transaction
        bus.request = 4'b0001;
        wait_grant(8);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        step();
        #2;
        nReset = 1'b0;
        #1;
        check_val("async_rst_grant", 32'(bus.grant), 32'd0);
        check_val("async_rst_idle", 32'(bus.busIdle), 32'd1);
        step();
        nReset = 1'b1;
        bus.request = '0;
        step();

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) bus.request = N'($urandom_range(0, (1 << N) - 1));
            bus.beginTransactionIn = ($urandom_range(0, 3) == 0);
            bus.endTransactionIn   = ($urandom_range(0, 5) == 0);
            bus.dataValidIn        = ($urandom_range(0, 2) == 0);
            bus.busErrorIn         = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.request = '0;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.dataValidIn        = 1'b0;
        bus.busErrorIn         = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Round-robin arbiter that shares the single shared system bus between up to NUM_MASTERS bus masters (CPU, DMA engines, camera/display controllers).
- Each master drives a request and receives a one-hot grant.
- The arbiter monitors the shared begin/end/error bus signals to track transaction ownership, and releases the bus when the transaction ends.
- Optionally runs a watchdog that aborts a stalled transaction.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- BEGIN_TIMEOUT, 16, cycles a granted master may take to assert beginTransaction before the grant is revoked (1..255).
- WATCHDOG_CYCLES, 1024, idle cycles inside a transaction before abort; used only with BUS_ARB_WATCHDOG_EN (1..65535).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- request  in  NUM_MASTERS  per-master bus request; level, held until grant.
- grant  out  NUM_MASTERS  one-hot registered grant (transactionGranted of each master).
- beginTransactionIn  in  1  shared bus begin strobe.
- endTransactionIn  in  1  shared bus end strobe.
- dataValidIn  in  1  shared bus data-valid.
- busErrorIn  in  1  shared bus error.
- activeMaster  out  3  index of the current/last granted master.
- busIdle  out  1  1 when no master holds the bus.
- endTransactionOut  out  1  arbiter-generated end strobe (watchdog abort).
- busErrorOut  out  1  arbiter-generated error strobe (watchdog abort).

Behaviour:
Reset (nReset=0, asynchronous):
- grant=0, activeMaster=NUM_MASTERS-1, busIdle=1, endTransactionOut=0, busErrorOut=0.
- State IDLE; counters cleared.

State machine (registered; all outputs registered):
- IDLE: if any request bit is set, select the winner, set the grant bit, go to GRANTED. busIdle falls in the same cycle as grant rises.
- GRANTED: count cycles since grant.
  - beginTransactionIn=1 → BUSY.
  - Granted master drops its request, or the count reaches BEGIN_TIMEOUT → grant=0, go to RELEASE.
- BUSY: grant is held regardless of request.
  - endTransactionIn=1 → grant=0, go to RELEASE.
  - busErrorIn without endTransactionIn keeps BUSY; the slave still ends the transaction.
- RELEASE: one mandatory dead cycle (bus turnaround); busIdle=1; go to IDLE.

Winner selection:
- Search starts at index activeMaster+1, modulo NUM_MASTERS; the first asserted request wins.
- activeMaster updates to the winner on grant.
- A master therefore cannot win twice in a row while any other master is requesting.

Latency:
- Request in IDLE at cycle t → grant at t+1.
- End at t → grant low at t+1, RELEASE at t+1, earliest new grant at t+2.

Boundary cases:
- beginTransactionIn and endTransactionIn in the same cycle in GRANTED: treat as a complete transaction → RELEASE.
- A begin strobe seen while in IDLE or RELEASE (rogue master) is ignored.
- Grant is never multi-hot. Grant is never asserted in RELEASE.
- Timeout counter is 8 bits and saturates.
- Reset mid-transaction drops the grant immediately (asynchronous).

Optional Feature:
BUS_ARB_WATCHDOG_EN:
- Defined: a 16-bit counter in BUSY clears on dataValidIn or beginTransactionIn and increments otherwise. On reaching WATCHDOG_CYCLES:
  - endTransactionOut=1 and busErrorOut=1 for exactly one cycle.
  - grant=0, go to RELEASE.
  - A natural endTransactionIn in the same cycle takes priority: no abort strobes.
- Undefined: endTransactionOut and busErrorOut are tied 0; no counter is instantiated.

Decomposition:
- Package bus_arb_pkg holds:
  - state encoding constants IDLE=0, GRANTED=1, BUSY=2, RELEASE=3;
  - the 3-bit master-index width.
- One natural sub-module, rr_priority_pick: combinational rotate / find-first / un-rotate. Input is the request vector and pointer; output is the one-hot winner and its index.

Test Plan:
- Reset then request=4'b0001 → grant=4'b0001 at t+1, activeMaster=0, busIdle=0. Begin, then end 5 cycles later → grant=0 next cycle, new grant no earlier than 2 cycles after end.
- request=4'b1111 held across 4 transactions → grants in order 0001, 0010, 0100, 1000, then 0001 again.
- Grant master 2, no begin for 16 cycles → grant drops at the BEGIN_TIMEOUT cycle, master 3 is granted after RELEASE.
- In BUSY, master drops its request and pulses busErrorIn → grant is held until endTransactionIn.
- nReset pulsed low mid-BUSY → grant=0 and busIdle=1 within the same cycle, without waiting for a clock edge.
- With BUS_ARB_WATCHDOG_EN and WATCHDOG_CYCLES=8: begin, no data for 8 cycles → single-cycle endTransactionOut=1 and busErrorOut=1, grant=0. Without the macro the same stimulus holds the grant indefinitely.
